mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single SPI memory master.
// Define MEM_ARB_TIMEOUT_EN to add an 8-bit WAIT watchdog that aborts with errN.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] addr0,
    input  logic        we0,
    input  logic [7:0]  wdata0,
    input  logic        sel0,
    input  logic        req1,
    input  logic [15:0] addr1,
    input  logic        we1,
    input  logic [7:0]  wdata1,
    input  logic        sel1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [7:0]  rdata,
    output logic        spi_start,
    output logic [15:0] spi_addr,
    output logic        spi_we,
    output logic [7:0]  spi_wdata,
    output logic        spi_sel,
    input  logic        spi_done,
    input  logic [7:0]  spi_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q;
    logic        port_q;
    logic        last_q;
    logic        start_q;
    logic        done0_q;
    logic        done1_q;
    logic [7:0]  rdata_q;
    logic [15:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic        sel_q;
    logic        gnt_d;

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0]  wdog_q;
    logic        tout_q;
    logic        err0_q;
    logic        err1_q;
`endif

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        gnt_d = 1'b0;
        gnt_d = req1 & (~req0 | ~last_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            port_q  <= 1'b0;
            last_q  <= 1'b1;
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            rdata_q <= 8'h00;
            addr_q  <= 16'h0000;
            we_q    <= 1'b0;
            wdata_q <= 8'h00;
            sel_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            wdog_q  <= 8'h00;
            tout_q  <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (req0 || req1) begin
                        port_q  <= gnt_d;
                        last_q  <= gnt_d;
                        addr_q  <= gnt_d ? addr1 : addr0;
                        we_q    <= gnt_d ? we1 : we0;
                        wdata_q <= gnt_d ? wdata1 : wdata0;
                        sel_q   <= gnt_d ? sel1 : sel0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b1;
                    state_q <= WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                    wdog_q  <= 8'h00;
                    tout_q  <= 1'b0;
`endif
                end
                WAIT: begin
                    if (spi_done) begin
                        if (!we_q) begin
                            rdata_q <= spi_rdata;
                        end
                        state_q <= RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    // Terminal count: this cycle would make the watchdog 255.
                    else if (wdog_q == 8'd254) begin
                        tout_q  <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
`endif
                end
                RESP: begin
                    done0_q <= ~port_q;
                    done1_q <= port_q;
`ifdef MEM_ARB_TIMEOUT_EN
                    err0_q  <= tout_q & ~port_q;
                    err1_q  <= tout_q & port_q;
                    tout_q  <= 1'b0;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata     = rdata_q;
    assign spi_start = start_q;
    assign spi_addr  = addr_q;
    assign spi_we    = we_q;
    assign spi_wdata = wdata_q;
    assign spi_sel   = sel_q;
    assign busy      = (state_q != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    assign err0 = err0_q;
    assign err1 = err1_q;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level
// model: round-robin grant, fixed latency, latched fields, rdata history.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic [15:0] addr0 = '0;
    logic        we0 = 1'b0;
    logic [7:0]  wdata0 = '0;
    logic        sel0 = 1'b0;
    logic        req1 = 1'b0;
    logic [15:0] addr1 = '0;
    logic        we1 = 1'b0;
    logic [7:0]  wdata1 = '0;
    logic        sel1 = 1'b0;
    logic        done0, done1, err0, err1;
    logic [7:0]  rdata;
    logic        spi_start;
    logic [15:0] spi_addr;
    logic        spi_we;
    logic [7:0]  spi_wdata;
    logic        spi_sel;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rdata = '0;
    logic        busy;

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state: who won last, what rdata must currently hold.
    bit         last_m = 1'b1;
    logic [7:0] rdata_m = 8'h00;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0), .sel0(sel0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1), .sel1(sel1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata(rdata), .spi_start(spi_start), .spi_addr(spi_addr),
        .spi_we(spi_we), .spi_wdata(spi_wdata), .spi_sel(spi_sel),
        .spi_done(spi_done), .spi_rdata(spi_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_busy", busy, 0);
        chk("rst_start", spi_start, 0);
        chk("rst_done", {done0, done1}, 0);
        chk("rst_err", {err0, err1}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_spi_fields", {spi_addr, spi_we, spi_wdata, spi_sel}, 0);
    endtask

    task automatic txn(input bit r0, input bit r1,
                       input logic [15:0] a0, input logic w0,
                       input logic [7:0] d0, input logic s0,
                       input logic [15:0] a1, input logic w1,
                       input logic [7:0] d1, input logic s1,
                       input int lat, input logic [7:0] rd,
                       input bit chg, input bit drp, input bit keep);
        bit g;
        logic [15:0] ea;
        logic ew, es;
        logic [7:0] ed;
        req0 = r0; addr0 = a0; we0 = w0; wdata0 = d0; sel0 = s0;
        req1 = r1; addr1 = a1; we1 = w1; wdata1 = d1; sel1 = s1;
        g = (r0 && r1) ? !last_m : r1;
        last_m = g;
        ea = g ? a1 : a0;
        ew = g ? w1 : w0;
        ed = g ? d1 : d0;
        es = g ? s1 : s0;
        spi_done = 1'($urandom_range(0, 1));
        spi_rdata = ~rd;
        tick();
        chk("busy_issue", busy, 1);
        chk("start_early", spi_start, 0);
        if (chg) begin
            addr0 = 16'hBEEF; addr1 = 16'hBEEF;
            wdata0 = ~d0; wdata1 = ~d1;
            we0 = ~w0; we1 = ~w1; sel0 = ~s0; sel1 = ~s1;
        end
        if (drp) begin
            req0 = 1'b0; req1 = 1'b0;
        end
        tick();
        spi_done = 1'b0;
        chk("start_pulse", spi_start, 1);
        chk("spi_addr", spi_addr, ea);
        chk("spi_ctl", {spi_we, spi_wdata, spi_sel}, {ew, ed, es});
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("start_once", spi_start, 0);
            chk("no_done_wait", {done0, done1}, 0);
            chk("busy_wait", busy, 1);
        end
        spi_done = 1'b1;
        spi_rdata = rd;
        tick();
        spi_done = 1'b0;
        spi_rdata = 8'($urandom);
        chk("no_done_resp", {done0, done1}, 0);
        chk("start_resp", spi_start, 0);
        if (!ew) rdata_m = rd;
        tick();
        chk("done_port", {done0, done1}, {!g, g});
        chk("err_clear", {err0, err1}, 0);
        chk("rdata", rdata, rdata_m);
        chk("spi_addr_hold", spi_addr, ea);
        chk("busy_done", busy, 0);
        if (!keep) begin
            req0 = 1'b0; req1 = 1'b0;
            tick();
            chk("done_single", {done0, done1}, 0);
            chk("idle", busy, 0);
        end
    endtask

    initial begin
        int n;
        bit r0, r1;
        #3;
        chk_reset();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset();

        // Single CPU read, shortest latency.
        txn(1, 0, 16'h1234, 0, 8'h00, 0, 16'h5555, 0, 8'h00, 0,
            0, 8'hA5, 0, 0, 0);

        // Three tie rounds straight after reset: 0, 1, 0.
        rst_n = 1'b0;
        #1;
        last_m = 1'b1;
        rdata_m = 8'h00;
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++)
            txn(1, 1, 16'h0A00 + 16'(k), 0, 8'h11, 0,
                16'h0B00 + 16'(k), 0, 8'h22, 1,
                k, 8'h40 + 8'(k), 0, 0, 0);

        // Loader write: rdata must not move.
        txn(0, 1, 16'h0000, 0, 8'h00, 0, 16'h00FF, 1, 8'h3C, 1,
            1, 8'hE7, 0, 0, 0);

        // Fields changing while busy, then request dropped mid-flight.
        txn(1, 0, 16'h2468, 0, 8'h00, 1, 16'h0000, 0, 8'h00, 0,
            2, 8'h5A, 1, 0, 0);
        txn(1, 1, 16'h1357, 0, 8'h77, 0, 16'h9ABC, 0, 8'h88, 1,
            1, 8'hC3, 0, 1, 0);

        // Request left high after done is served again.
        txn(0, 1, 16'h0000, 0, 8'h00, 0, 16'h4321, 0, 8'h00, 0,
            0, 8'h19, 0, 0, 1);
        txn(0, 1, 16'h0000, 0, 8'h00, 0, 16'h4321, 0, 8'h00, 0,
            0, 8'h91, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(1, 3);
            r0 = n[0];
            r1 = n[1];
            txn(r0, r1, 16'($urandom), 1'($urandom), 8'($urandom),
                1'($urandom), 16'($urandom), 1'($urandom),
                8'($urandom), 1'($urandom), $urandom_range(0, 5),
                8'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        // Reset while waiting on the SPI master, late spi_done afterwards.
        req0 = 1'b1; addr0 = 16'h7777; we0 = 1'b0; sel0 = 1'b0;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset();
        last_m = 1'b1;
        rdata_m = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;
        spi_done = 1'b1;
        spi_rdata = 8'hFF;
        tick();
        spi_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", {done0, done1}, 0);
            chk("abort_idle", busy, 0);
            chk("abort_rdata", rdata, 0);
            tick();
        end
        txn(1, 0, 16'h0101, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0,
            0, 8'h6B, 0, 0, 0);
        txn(1, 1, 16'h0202, 0, 8'h00, 0, 16'h0303, 0, 8'h00, 0,
            0, 8'h6C, 0, 0, 0);

        // Withheld spi_done.
        req0 = 1'b1; addr0 = 16'hCAFE; we0 = 1'b0;
        last_m = 1'b0;
        tick();
        req0 = 1'b0;
        tick();
        n = 0;
        for (int k = 2; k < 400; k++) begin
            tick();
            if (n == 0 && (done0 || done1)) begin
                n = k;
`ifdef MEM_ARB_TIMEOUT_EN
                chk("tout_port", {done0, done1}, 2'b10);
                chk("tout_err", {err0, err1}, 2'b10);
                chk("tout_rdata", rdata, rdata_m);
`endif
            end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("tout_edge", n, 257);
        chk("tout_idle", busy, 0);
`else
        chk("hang_no_done", n, 0);
        chk("hang_busy", busy, 1);
        chk("hang_err", {err0, err1}, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
